// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor: operand request (start, a, b)
// from the master, status and serial/parallel results back from the slave.
// Ports: master drives start/a/b; slave drives busy/done/diff/borrow_out/
// d_bit/d_valid, plus ovf when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             d_bit;
  logic             d_valid;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, d_bit, d_valid, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, d_bit, d_valid, ovf
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, d_bit, d_valid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, d_bit, d_valid
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial two's-complement subtractor (a - b), LSB first, one
//           full-subtractor cell plus a borrow flip-flop.
// Latency : WIDTH cycles of SHIFT after the accepting edge, then a one-cycle
//           done pulse; one operation per WIDTH+2 cycles at best.
// Backpressure: none; start is only sampled in IDLE and is ignored while an
//           operation is in flight or done is being presented.
// Ports   : clk, rst (async, active high); bus (slave modport) carrying
//           start/a/b in and busy/done/diff/borrow_out/d_bit/d_valid out.
// Option  : define SERIAL_SUB_OVF_EN to add the registered signed-overflow
//           output bus.ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_subtractor_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt;

  logic             busy;
  logic             done;
  logic             accept;
  logic             last;
  logic             a0;
  logic             b0;
  logic             d_cell;
  logic             borrow_cell;

  // Full-subtractor cell on the current LSBs.
  assign a0          = shift_a[0];
  assign b0          = shift_b[0];
  assign d_cell      = a0 ^ b0 ^ borrow_q;
  assign borrow_cell = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);

  assign accept = (state == IDLE) && bus.start;
  // Counter still holds WIDTH-1 on the edge that processes the final bit.
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operands shift out LSB first, difference bits enter at the MSB
  // so the result is LSB-aligned after exactly WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_a  <= '0;
      shift_b  <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      shift_a  <= bus.a;
      shift_b  <= bus.b;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (state == SHIFT) begin
      shift_a  <= {1'b0, shift_a[WIDTH-1:1]};
      shift_b  <= {1'b0, shift_b[WIDTH-1:1]};
      diff_q   <= {d_cell, diff_q[WIDTH-1:1]};
      borrow_q <= borrow_cell;
      cnt      <= cnt + CW'(1);
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are kept aside because the shift registers lose them.
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (last) begin
      // d_cell is the result MSB on the final edge.
      ovf_q <= (a_msb ^ b_msb) & (d_cell ^ a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  // Cell output is only meaningful while shifting; keep it quiet otherwise.
  assign bus.d_bit      = busy & d_cell;
  assign bus.d_valid    = busy;

endmodule
